// File: rtl/prod_accum.sv
// Sums N_TERMS unsigned 8-bit products into an ACC_W-bit result with a valid/ready handshake.
// Build option: define PROD_ACCUM_SAT_EN to clamp Acc at all-ones on overflow instead of wrapping.
module prod_accum #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       Prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] Acc,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic [3:0]       Count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam logic [3:0] LastCount = 4'(N_TERMS);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             xfer;
  logic [ACC_W:0]   sum;
  logic [3:0]       count_inc;

  assign xfer      = prod_valid & prod_ready;
  // One extra bit so the carry out of the accumulator is visible.
  assign sum       = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, Prod};
  assign count_inc = count_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    case (state_q)
      StIdle: begin
        prod_ready = 1'b1;
        if (clear) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (xfer) begin
          acc_d   = ACC_W'(Prod);
          count_d = 4'd1;
          ovf_d   = 1'b0;
          state_d = (N_TERMS == 1) ? StHold : StAccum;
        end
      end
      StAccum: begin
        prod_ready = 1'b1;
        if (clear) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end else if (xfer) begin
          count_d = count_inc;
          if (sum[ACC_W]) ovf_d = 1'b1;
`ifdef PROD_ACCUM_SAT_EN
          // Once clamped, further adds keep carrying (or add zero), so Acc stays all-ones.
          acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          if (count_inc == LastCount) state_d = StHold;
        end
      end
      StHold: begin
        acc_valid = 1'b1;
        if (acc_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Acc   = acc_q;
  assign ovf   = ovf_q;
  assign Count = count_q;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: three instances (defaults, ACC_W=8, N_TERMS=1)
// compared every cycle against a sum-of-accepted-products reference model.
module tb_prod_accum;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] prod [3];
  logic       pv   [3];
  logic       clr  [3];
  logic       ar   [3];
  logic       prdy [3];
  logic       avld [3];
  logic       ovfo [3];
  logic [3:0] cnt  [3];
  logic [11:0] acc0;
  logic [7:0]  acc1;
  logic [11:0] acc2;

  int unsigned msum [3];
  int unsigned mcnt [3];
  int vectors = 0;
  int errors  = 0;

  always #5 Clk = ~Clk;

  prod_accum u_d0 (
    .Clk(Clk), .Reset(Reset), .Prod(prod[0]), .prod_valid(pv[0]), .prod_ready(prdy[0]),
    .clear(clr[0]), .Acc(acc0), .acc_valid(avld[0]), .acc_ready(ar[0]), .ovf(ovfo[0]),
    .Count(cnt[0])
  );

  prod_accum #(.N_TERMS(4), .ACC_W(8)) u_d1 (
    .Clk(Clk), .Reset(Reset), .Prod(prod[1]), .prod_valid(pv[1]), .prod_ready(prdy[1]),
    .clear(clr[1]), .Acc(acc1), .acc_valid(avld[1]), .acc_ready(ar[1]), .ovf(ovfo[1]),
    .Count(cnt[1])
  );

  prod_accum #(.N_TERMS(1), .ACC_W(12)) u_d2 (
    .Clk(Clk), .Reset(Reset), .Prod(prod[2]), .prod_valid(pv[2]), .prod_ready(prdy[2]),
    .clear(clr[2]), .Acc(acc2), .acc_valid(avld[2]), .acc_ready(ar[2]), .ovf(ovfo[2]),
    .Count(cnt[2])
  );

  function automatic int unsigned nt(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int unsigned wd(input int k);
    return (k == 1) ? 8 : 12;
  endfunction

  function automatic logic [31:0] obs_acc(input int k);
    if (k == 0) return {20'd0, acc0};
    if (k == 1) return {24'd0, acc1};
    return {20'd0, acc2};
  endfunction

  // Expected result from the true (unbounded) sum of accepted products.
  function automatic logic [31:0] exp_acc(input int k);
    int unsigned maxv = (32'd1 << wd(k)) - 1;
`ifdef PROD_ACCUM_SAT_EN
    return (msum[k] > maxv) ? maxv : msum[k];
`else
    return msum[k] & maxv;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      string t = $sformatf("d%0d", k);
      logic  hold = (mcnt[k] == nt(k));
      chk({t, ".acc_valid"}, 32'(avld[k]), 32'(hold));
      chk({t, ".prod_ready"}, 32'(prdy[k]), 32'(!hold));
      chk({t, ".count"}, 32'(cnt[k]), mcnt[k]);
      chk({t, ".acc"}, obs_acc(k), exp_acc(k));
      chk({t, ".ovf"}, 32'(ovfo[k]), 32'(msum[k] > ((32'd1 << wd(k)) - 1)));
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    for (int k = 0; k < 3; k++) begin
      if (mcnt[k] == nt(k)) begin
        if (ar[k]) begin
          msum[k] = 0;
          mcnt[k] = 0;
        end
      end else if (clr[k]) begin
        msum[k] = 0;
        mcnt[k] = 0;
      end else if (pv[k]) begin
        msum[k] += prod[k];
        mcnt[k]++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      pv[k] = 1'b0; clr[k] = 1'b0; ar[k] = 1'b0; prod[k] = 8'd0;
    end
  endtask

  task automatic push(input int k, input logic [7:0] p);
    pv[k] = 1'b1;
    prod[k] = p;
    tick();
    pv[k] = 1'b0;
  endtask

  task automatic consume(input int k);
    ar[k] = 1'b1;
    tick();
    ar[k] = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; asserts and releases Reset between edges.
  task automatic async_reset();
    #2 Reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      msum[k] = 0;
      mcnt[k] = 0;
    end
    check_all();
    chk("rst.acc0", obs_acc(0), 32'd0);
    #2 Reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_all();
    for (int k = 0; k < 3; k++) begin
      msum[k] = 0;
      mcnt[k] = 0;
    end
    #1 check_all();
    #10 Reset = 1'b1;

    // Basic sum.
    push(0, 8'd15); push(0, 8'd30); push(0, 8'd45); push(0, 8'd60);
    chk("basic.acc", obs_acc(0), 32'd150);
    chk("basic.count", 32'(cnt[0]), 32'd4);
    chk("basic.valid", 32'(avld[0]), 32'd1);
    consume(0);

    // Handshake with gaps and a stalled consumer.
    push(0, 8'd1); tick(); push(0, 8'd2); tick(); tick(); push(0, 8'd3); push(0, 8'd4);
    pv[0] = 1'b1; prod[0] = 8'd99; clr[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.acc", obs_acc(0), 32'd10);
      chk("hold.ready", 32'(prdy[0]), 32'd0);
    end
    pv[0] = 1'b0; clr[0] = 1'b0;
    consume(0);
    chk("hold.release", 32'(avld[0]), 32'd0);

    // Clear beats a simultaneous transfer.
    push(0, 8'd5); push(0, 8'd6);
    pv[0] = 1'b1; clr[0] = 1'b1; prod[0] = 8'd7;
    tick();
    pv[0] = 1'b0; clr[0] = 1'b0;
    chk("clear.count", 32'(cnt[0]), 32'd0);
    for (int i = 0; i < 4; i++) push(0, 8'd1);
    chk("clear.acc", obs_acc(0), 32'd4);
    consume(0);

    // Overflow on the 8-bit instance.
    push(1, 8'd200); push(1, 8'd100); push(1, 8'd0); push(1, 8'd0);
`ifdef PROD_ACCUM_SAT_EN
    chk("ovf.acc", obs_acc(1), 32'd255);
`else
    chk("ovf.acc", obs_acc(1), 32'd44);
`endif
    chk("ovf.flag", 32'(ovfo[1]), 32'd1);
    consume(1);

    // Asynchronous reset mid-accumulation, then a clean result.
    push(0, 8'd3); push(0, 8'd4);
    async_reset();
    push(0, 8'd9); push(0, 8'd8); push(0, 8'd7); push(0, 8'd6);
    chk("rst.next", obs_acc(0), 32'd30);
    consume(0);

    // Single-term result.
    push(2, 8'd225);
    chk("n1.valid", 32'(avld[2]), 32'd1);
    chk("n1.acc", obs_acc(2), 32'd225);
    consume(2);

    // Randomized traffic on all instances.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        pv[k]   = ($urandom_range(3) != 0);
        prod[k] = 8'($urandom);
        clr[k]  = ($urandom_range(15) == 0);
        ar[k]   = ($urandom_range(1) != 0);
      end
      tick();
      if (i % 150 == 75) async_reset();
    end
    idle_all();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
